staff_frame_reader: RTL and testbench

// - Read side of the 320x180 staff frame buffer that the note-pixel writer fills.
// - Scans the buffer in raster order from the 720p video timing counters.
// - Upscales each buffer pixel 4x4 to 1280x720.
// - Converts the 8-bit gray image index to 24-bit RGB and overlays the current-cell cursor.
// - Outputs sync/active signals delayed to stay aligned with the pixel data.

---
 rtl/staff_frame_reader.sv | 142 ++++++++++++++
 tb/tb_staff_frame_reader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/staff_frame_reader.sv
// Raster-scans the 320x180 staff frame buffer, upscales it 4x4 to 720p, maps gray to RGB and overlays the cell cursor.
// Latency 4 cycles from hcount/vcount to RGB and delayed syncs. Optional macro: STAFF_LINE_OVERLAY_EN.
module staff_frame_reader #(
  parameter int FB_WIDTH    = 320,
  parameter int FB_HEIGHT   = 180,
  parameter int SCALE_SHIFT = 2,
  parameter int CELL_WIDTH  = 5,
  parameter int RD_LATENCY  = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        active_draw_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        new_frame_in,
  input  logic [5:0]  current_staff_cell_in,
  input  logic        freeze_in,
  output logic [15:0] fb_addr_out,
  input  logic [15:0] fb_data_in,
  output logic [7:0]  red_out,
  output logic [7:0]  green_out,
  output logic [7:0]  blue_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        active_draw_out,
  output logic [7:0]  frame_count_out
);

  typedef enum logic {WAIT_SYNC, SCAN} state_t;

  state_t      r_state;
  logic [5:0]  r_cursor;
  logic [7:0]  r_frame_count;
  logic [15:0] r_addr;
  logic        r_s0_vld;
  logic [8:0]  r_s0_x;
  logic [7:0]  r_s0_y;
  logic        r_p_vld [RD_LATENCY];
  logic [8:0]  r_p_x   [RD_LATENCY];
  logic [7:0]  r_p_y   [RD_LATENCY];
  logic [2:0]  r_sync  [RD_LATENCY+1];
  logic [2:0]  r_sync_out;
  logic [23:0] r_rgb;

  logic        w_in_range;
  logic [8:0]  w_x;
  logic [7:0]  w_y;
  logic [15:0] w_addr;
  logic [8:0]  w_cur_lo;
  logic [8:0]  w_cur_hi;
  logic        w_hit;
  logic [7:0]  w_g_raw;
  logic [7:0]  w_g;
  logic        w_unused_hi;

  assign w_in_range = (hcount_in < 11'(FB_WIDTH << SCALE_SHIFT)) &&
                      (vcount_in < 10'(FB_HEIGHT << SCALE_SHIFT));
  assign w_x = 9'(hcount_in >> SCALE_SHIFT);
  assign w_y = 8'(vcount_in >> SCALE_SHIFT);
  // row*320 as shift-add; max address 57599 fits 16 bits
  assign w_addr = {w_y, 8'b0} + {2'b0, w_y, 6'b0} + {7'b0, w_x};

  assign w_cur_lo = 9'(r_cursor) * 9'(CELL_WIDTH);
  assign w_cur_hi = w_cur_lo + 9'(CELL_WIDTH - 1);
  assign w_hit    = (r_p_x[RD_LATENCY-1] >= w_cur_lo) && (r_p_x[RD_LATENCY-1] <= w_cur_hi);

  assign w_g_raw     = fb_data_in[7:0];
  assign w_unused_hi = ^fb_data_in[15:8];

`ifdef STAFF_LINE_OVERLAY_EN
  logic w_line_row;
  assign w_line_row = (r_p_y[RD_LATENCY-1] == 8'd75) || (r_p_y[RD_LATENCY-1] == 8'd81) ||
                      (r_p_y[RD_LATENCY-1] == 8'd87) || (r_p_y[RD_LATENCY-1] == 8'd93) ||
                      (r_p_y[RD_LATENCY-1] == 8'd99);
  assign w_g = (w_line_row && (w_g_raw >= 8'h94)) ? 8'h94 : w_g_raw;
`else
  logic w_unused_row;
  assign w_unused_row = ^r_p_y[RD_LATENCY-1];
  assign w_g = w_g_raw;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state       <= WAIT_SYNC;
      r_cursor      <= 6'd0;
      r_frame_count <= 8'd0;
      r_addr        <= 16'd0;
      r_s0_vld      <= 1'b0;
      r_s0_x        <= 9'd0;
      r_s0_y        <= 8'd0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        r_p_vld[i] <= 1'b0;
        r_p_x[i]   <= 9'd0;
        r_p_y[i]   <= 8'd0;
      end
      for (int i = 0; i <= RD_LATENCY; i++) r_sync[i] <= 3'd0;
      r_sync_out <= 3'd0;
      r_rgb      <= 24'd0;
    end else begin
      if (new_frame_in) begin
        r_state <= SCAN;
        if (r_state == SCAN) r_frame_count <= r_frame_count + 8'd1;
        // cursor only moves at frame start, so a frame never shows two positions
        if (!freeze_in) r_cursor <= current_staff_cell_in;
      end

      r_addr   <= (r_state == SCAN && w_in_range) ? w_addr : 16'd0;
      r_s0_vld <= active_draw_in && (r_state == SCAN);
      r_s0_x   <= w_x;
      r_s0_y   <= w_y;

      r_p_vld[0] <= r_s0_vld;
      r_p_x[0]   <= r_s0_x;
      r_p_y[0]   <= r_s0_y;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_p_vld[i] <= r_p_vld[i-1];
        r_p_x[i]   <= r_p_x[i-1];
        r_p_y[i]   <= r_p_y[i-1];
      end

      r_sync[0] <= {hsync_in, vsync_in, active_draw_in};
      for (int i = 1; i <= RD_LATENCY; i++) r_sync[i] <= r_sync[i-1];
      r_sync_out <= r_sync[RD_LATENCY];

      if (!r_p_vld[RD_LATENCY-1]) r_rgb <= 24'd0;
      else if (w_hit)             r_rgb <= {w_g >> 1, w_g >> 1, 8'hFF};
      else                        r_rgb <= {w_g, w_g, w_g};
    end
  end

  assign fb_addr_out     = r_addr;
  assign frame_count_out = r_frame_count;
  assign red_out         = r_rgb[23:16];
  assign green_out       = r_rgb[15:8];
  assign blue_out        = r_rgb[7:0];
  assign hsync_out       = r_sync_out[2];
  assign vsync_out       = r_sync_out[1];
  assign active_draw_out = r_sync_out[0];

endmodule

// File: tb/tb_staff_frame_reader.sv
// Bench for staff_frame_reader: a 2-cycle BRAM model, a reference model feeding a scoreboard queue, and hand-checked pixel vectors.
module tb_staff_frame_reader;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        active_draw_in, hsync_in, vsync_in, new_frame_in, freeze_in;
  logic [5:0]  current_staff_cell_in;
  logic [15:0] fb_addr_out;
  logic [15:0] fb_data_in = 16'd0;
  logic [15:0] r_d1 = 16'd0;
  logic [7:0]  red_out, green_out, blue_out, frame_count_out;
  logic        hsync_out, vsync_out, active_draw_out;

  always #5 clk_in = ~clk_in;

  staff_frame_reader dut (
    .clk_in(clk_in), .rst_in(rst_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .active_draw_in(active_draw_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .new_frame_in(new_frame_in), .current_staff_cell_in(current_staff_cell_in),
    .freeze_in(freeze_in), .fb_addr_out(fb_addr_out), .fb_data_in(fb_data_in),
    .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .active_draw_out(active_draw_out),
    .frame_count_out(frame_count_out)
  );

  function automatic logic [7:0] gray(input logic [15:0] addr);
    int row, col;
    row = int'(addr) / 320;
    col = int'(addr) % 320;
    if (row == 81) return 8'hFF;
    if (row == 0 && (col == 0 || col == 50)) return 8'h40;
    return 8'((row * 3 + col) & 255);
  endfunction

  // frame buffer with two cycles of read latency; upper byte is junk the DUT must ignore
  always @(posedge clk_in) begin
    r_d1       <= {8'hA5, gray(fb_addr_out)};
    fb_data_in <= r_d1;
  end

  typedef struct packed {
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        ad;
  } exp_t;

  typedef struct {
    logic [10:0] hc;
    logic [9:0]  vc;
    logic [23:0] rgb;
    logic [15:0] addr;
  } vec_t;

  exp_t        q[$];
  vec_t        tab[10];
  int          n_cmp = 0;
  int          n_err = 0;
  bit          m_scan;
  logic [5:0]  m_cur;
  logic [7:0]  m_fc;
  logic [15:0] m_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic step(input logic [10:0] hc, input logic [9:0] vc, input bit nf, input bit rs,
                      input bit use_tab, input logic [23:0] trgb, input logic [15:0] taddr);
    exp_t e;
    int row, col, lo;
    logic [15:0] addr;
    logic [7:0]  g;
    logic        valid;
    @(negedge clk_in);
    chk("fb_addr", 32'(fb_addr_out), 32'(m_addr));
    chk("frame_count", 32'(frame_count_out), 32'(m_fc));
    if (q.size() == 4) begin
      e = q.pop_front();
      chk("rgb", {8'd0, red_out, green_out, blue_out}, {8'd0, e.rgb});
      chk("syncs", {29'd0, hsync_out, vsync_out, active_draw_out}, {29'd0, e.hs, e.vs, e.ad});
    end
    hcount_in      = hc;
    vcount_in      = vc;
    active_draw_in = (hc < 11'd1280) && (vc < 10'd720);
    hsync_in       = 1'($urandom);
    vsync_in       = 1'($urandom);
    new_frame_in   = nf;
    rst_in         = rs;
    e.hs = hsync_in;
    e.vs = vsync_in;
    e.ad = active_draw_in;
    if (rs) begin
      foreach (q[i]) q[i] = '0;
      q.push_back('0);
      m_scan = 1'b0;
      m_cur  = 6'd0;
      m_fc   = 8'd0;
      m_addr = 16'd0;
    end else begin
      row  = int'(vc) >> 2;
      col  = int'(hc) >> 2;
      addr = (hc < 11'd1280 && vc < 10'd720) ? 16'(row * 320 + col) : 16'd0;
      valid = active_draw_in && m_scan;
      g = gray(addr);
`ifdef STAFF_LINE_OVERLAY_EN
      if ((row == 75 || row == 81 || row == 87 || row == 93 || row == 99) && g >= 8'h94) g = 8'h94;
`endif
      lo = int'(m_cur) * 5;
      if (!valid)                     e.rgb = 24'd0;
      else if (col >= lo && col <= lo + 4) e.rgb = {g >> 1, g >> 1, 8'hFF};
      else                            e.rgb = {g, g, g};
      m_addr = m_scan ? addr : 16'd0;
      if (use_tab) begin
        e.rgb  = trgb;
        m_addr = taddr;
      end
      q.push_back(e);
      if (nf) begin
        if (m_scan) m_fc = m_fc + 8'd1;
        if (!freeze_in) m_cur = current_staff_cell_in;
        m_scan = 1'b1;
      end
    end
  endtask

  task automatic blank();
    step(11'd1400, 10'd0, 1'b0, 1'b0, 1'b0, 24'd0, 16'd0);
  endtask

  task automatic frame_pulse();
    repeat (4) blank();
    step(11'd1400, 10'd0, 1'b1, 1'b0, 1'b0, 24'd0, 16'd0);
    repeat (4) blank();
  endtask

  task automatic pix(input logic [10:0] hc, input logic [9:0] vc, input logic [23:0] rgb,
                     input logic [15:0] addr);
    step(hc, vc, 1'b0, 1'b0, 1'b1, rgb, addr);
  endtask

  initial begin
    tab[0] = '{11'd0,    10'd0,   24'h404040, 16'd0};
    tab[1] = '{11'd200,  10'd0,   24'h2020FF, 16'd50};
    tab[2] = '{11'd219,  10'd3,   24'h1B1BFF, 16'd54};
    tab[3] = '{11'd220,  10'd0,   24'h373737, 16'd55};
    tab[4] = '{11'd196,  10'd0,   24'h313131, 16'd49};
    tab[5] = '{11'd1300, 10'd0,   24'h000000, 16'd0};
    tab[6] = '{11'd8,    10'd4,   24'h050505, 16'd322};
    tab[7] = '{11'd1279, 10'd719, 24'h585858, 16'd57599};
`ifdef STAFF_LINE_OVERLAY_EN
    tab[8] = '{11'd40,   10'd324, 24'h949494, 16'd25930};
    tab[9] = '{11'd0,    10'd300, 24'h949494, 16'd24000};
`else
    tab[8] = '{11'd40,   10'd324, 24'hFFFFFF, 16'd25930};
    tab[9] = '{11'd0,    10'd300, 24'hE1E1E1, 16'd24000};
`endif

    rst_in = 1'b1; hcount_in = '0; vcount_in = '0; active_draw_in = 1'b0;
    hsync_in = 1'b0; vsync_in = 1'b0; new_frame_in = 1'b0; freeze_in = 1'b0;
    current_staff_cell_in = 6'd10;
    m_scan = 1'b0; m_cur = '0; m_fc = '0; m_addr = '0;
    repeat (2) @(posedge clk_in);

    repeat (4) step(11'd1400, 10'd0, 1'b0, 1'b1, 1'b0, 24'd0, 16'd0);
    // active pixels before the first frame start stay black
    for (int i = 0; i < 8; i++) step(11'(i * 4), 10'd0, 1'b0, 1'b0, 1'b0, 24'd0, 16'd0);

    frame_pulse();
    foreach (tab[i]) begin
      pix(tab[i].hc, tab[i].vc, tab[i].rgb, tab[i].addr);
      blank();
    end

    current_staff_cell_in = 6'd11;
    pix(11'd220, 10'd0, 24'h373737, 16'd55);
    frame_pulse();
    pix(11'd220, 10'd0, 24'h1B1BFF, 16'd55);
    freeze_in = 1'b1;
    current_staff_cell_in = 6'd10;
    frame_pulse();
    pix(11'd220, 10'd0, 24'h1B1BFF, 16'd55);
    pix(11'd200, 10'd0, 24'h404040, 16'd50);
    freeze_in = 1'b0;
    current_staff_cell_in = 6'd63;
    frame_pulse();
    pix(11'd1260, 10'd0, 24'h1D1DFF, 16'd315);
    pix(11'd1256, 10'd0, 24'h3A3A3A, 16'd314);
    pix(11'd1279, 10'd0, 24'h1F1FFF, 16'd319);

    // full line at vcount 360 with a reset dropped in the middle
    for (int h = 0; h < 1280; h++) step(11'(h), 10'd360, 1'b0, (h == 640), 1'b0, 24'd0, 16'd0);
    repeat (4) blank();
    current_staff_cell_in = 6'd10;
    frame_pulse();
    pix(11'd200, 10'd0, 24'h2020FF, 16'd50);

    // frame counter wraps 255 -> 0
    for (int f = 0; f < 256; f++) frame_pulse();
    for (int i = 0; i < 64; i++) step(11'(i * 20), 10'(i * 11), 1'b0, 1'b0, 1'b0, 24'd0, 16'd0);
    repeat (5) blank();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
